// File: rtl/sobel_window_kernel.sv
// sobel_window_kernel: 3x3 Sobel window, |Gx|+|Gy| magnitude with saturation or threshold, one result per Enable.
// Ports: CLK/Reset (async, active-high); Enable advances the whole pipeline;
//        Row0In/Row1In/Row2In = oldest/middle/newest line pixel of the incoming column;
//        DataOut = edge pixel, ValidOut = interior window, FrameDone = last pixel of frame accepted.
module sobel_window_kernel #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int THRESHOLD  = 0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [7:0] Row0In,
  input  logic [7:0] Row1In,
  input  logic [7:0] Row2In,
  output logic [7:0] DataOut,
  output logic       ValidOut,
  output logic       FrameDone
);
  localparam int XW = $clog2(IMG_WIDTH) < 2 ? 2 : $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT) < 2 ? 2 : $clog2(IMG_HEIGHT);
  localparam logic [11:0] THR = 12'(THRESHOLD);
  logic [2:0][2:0][7:0] p_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic int1_q, int2_q, last_x, last_y;
  logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
  logic [10:0] ax, ay;
  logic [11:0] mag;
  logic [7:0] data_d;
  function automatic logic [10:0] sum3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
  endfunction
  always_comb begin
    last_x = x_q == XW'(IMG_WIDTH - 1);
    last_y = y_q == YW'(IMG_HEIGHT - 1);
    x_d = last_x ? '0 : x_q + 1'b1;
    y_d = !last_x ? y_q : last_y ? '0 : y_q + 1'b1;
    // 11-bit two's complement difference of two 0..1020 sums never overflows
    gx_d = signed'(sum3(p_q[0][2], p_q[1][2], p_q[2][2]) - sum3(p_q[0][0], p_q[1][0], p_q[2][0]));
    gy_d = signed'(sum3(p_q[2][0], p_q[2][1], p_q[2][2]) - sum3(p_q[0][0], p_q[0][1], p_q[0][2]));
    ax = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag = {1'b0, ax} + {1'b0, ay};
    data_d = THRESHOLD == 0 ? (mag > 12'd255 ? 8'hFF : mag[7:0]) : (mag >= THR ? 8'hFF : 8'h00);
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      p_q <= '0;
      x_q <= '0;
      y_q <= '0;
      int1_q <= 1'b0;
      int2_q <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
      DataOut <= '0;
      ValidOut <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      FrameDone <= Enable && last_x && last_y;
      if (Enable) begin
        // column 2 is newest; each row shifts one column toward 0
        p_q <= {Row2In, p_q[2][2:1], Row1In, p_q[1][2:1], Row0In, p_q[0][2:1]};
        x_q <= x_d;
        y_q <= y_d;
        int1_q <= x_q >= XW'(2) && y_q >= YW'(2);
        gx_q <= gx_d;
        gy_q <= gy_d;
        int2_q <= int1_q;
        DataOut <= data_d;
        ValidOut <= int2_q;
      end
    end
endmodule

// File: tb/tb_sobel_window_kernel.sv
// tb_sobel_window_kernel: randomized and directed checks of sobel_window_kernel against a column-history model.
module tb_sobel_window_kernel;
  localparam int W = 8, H = 6;
  logic CLK = 1'b0, Reset = 1'b1, Enable = 1'b0;
  logic [7:0] Row0In = '0, Row1In = '0, Row2In = '0;
  logic [7:0] d0, d100, d80;
  logic v0, v100, v80, f0, f100, f80;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  sobel_window_kernel #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(0)) dut (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .Row0In(Row0In), .Row1In(Row1In), .Row2In(Row2In),
    .DataOut(d0), .ValidOut(v0), .FrameDone(f0));
  sobel_window_kernel #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(100)) dut_t100 (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .Row0In(Row0In), .Row1In(Row1In), .Row2In(Row2In),
    .DataOut(d100), .ValidOut(v100), .FrameDone(f100));
  sobel_window_kernel #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(80)) dut_t80 (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .Row0In(Row0In), .Row1In(Row1In), .Row2In(Row2In),
    .DataOut(d80), .ValidOut(v80), .FrameDone(f80));
  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int outpix(input int m, input int t);
    return t == 0 ? (m > 255 ? 255 : m) : (m >= t ? 255 : 0);
  endfunction
  int hist [0:1023][3];
  int cnt = 0, exp_d0 = 0, exp_d100 = 0, exp_d80 = 0;
  int mj, mp, ml, mm, mr, gx, gy, mag;
  logic exp_valid = 1'b0, fd_exp = 1'b0, last_en = 1'b0;
  initial forever begin
    @(posedge CLK or posedge Reset);
    if (Reset) begin
      cnt = 0;
      exp_valid = 1'b0;
      fd_exp = 1'b0;
      last_en = 1'b0;
    end else begin
      last_en = Enable;
      fd_exp = 1'b0;
      if (Enable) begin
        cnt++;
        hist[cnt % 1024] = '{int'(Row0In), int'(Row1In), int'(Row2In)};
        fd_exp = (cnt % (W * H)) == 0;
        exp_valid = 1'b0;
        if (cnt >= 3) begin
          mj = cnt - 2;
          mp = mj - 1;
          exp_valid = (mp % W) >= 2 && ((mp / W) % H) >= 2;
          if (exp_valid) begin
            ml = (mj - 2) % 1024;
            mm = (mj - 1) % 1024;
            mr = mj % 1024;
            gx = (hist[mr][0] + 2 * hist[mr][1] + hist[mr][2]) - (hist[ml][0] + 2 * hist[ml][1] + hist[ml][2]);
            gy = (hist[ml][2] + 2 * hist[mm][2] + hist[mr][2]) - (hist[ml][0] + 2 * hist[mm][0] + hist[mr][0]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            exp_d0 = outpix(mag, 0);
            exp_d100 = outpix(mag, 100);
            exp_d80 = outpix(mag, 80);
          end
        end
      end
    end
  end
  int nvalid = 0, nfd = 0, nz = 0, nff = 0, n80 = 0, t100z = 0, t80ff = 0;
  always @(negedge CLK) if (!Reset) begin
    expect_eq("valid_t0", int'(v0), int'(exp_valid));
    expect_eq("valid_t100", int'(v100), int'(exp_valid));
    expect_eq("valid_t80", int'(v80), int'(exp_valid));
    expect_eq("fdone_t0", int'(f0), int'(fd_exp));
    expect_eq("fdone_t100", int'(f100), int'(fd_exp));
    expect_eq("fdone_t80", int'(f80), int'(fd_exp));
    if (exp_valid) begin
      expect_eq("data_t0", int'(d0), exp_d0);
      expect_eq("data_t100", int'(d100), exp_d100);
      expect_eq("data_t80", int'(d80), exp_d80);
    end
    if (v0 && last_en) begin
      nvalid++;
      nz += int'(d0 == 8'd0);
      nff += int'(d0 == 8'd255);
      n80 += int'(d0 == 8'd80);
      t100z += int'(d100 == 8'd0);
      t80ff += int'(d80 == 8'd255);
    end
    nfd += int'(f0);
  end
  int pos = 0, mode = 0;
  int s_valid, s_fd, s_z, s_ff, s_80, s_t100z, s_t80ff;
  function automatic logic [7:0] pix(input int x);
    return mode == 0 ? 8'h80 : mode == 1 ? (x >= 4 ? 8'd100 : 8'd0) : mode == 2 ? 8'(10 * x) : 8'($urandom_range(0, 255));
  endfunction
  task automatic cyc(input bit en);
    int x;
    @(negedge CLK);
    #1;
    Enable = en;
    x = pos % W;
    if (en) begin
      pos++;
      Row0In = pix(x);
      Row1In = pix(x);
      Row2In = pix(x);
    end else begin
      Row0In = 8'($urandom);
      Row1In = 8'($urandom);
      Row2In = 8'($urandom);
    end
  endtask
  task automatic run(input int m, input int n, input bit rnd);
    bit en;
    mode = m;
    for (int i = 0; i < n;) begin
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(en);
      if (en) i++;
    end
    cyc(1'b0);
  endtask
  task automatic mark();
    s_valid = nvalid; s_fd = nfd; s_z = nz; s_ff = nff; s_80 = n80; s_t100z = t100z; s_t80ff = t80ff;
  endtask
  task automatic do_reset();
    @(negedge CLK);
    #1;
    Enable = 1'b0;
    Reset = 1'b1;
    pos = 0;
    #1;
    expect_eq("rst_data", int'(d0), 0);
    expect_eq("rst_valid", int'(v0), 0);
    expect_eq("rst_fdone", int'(f0), 0);
    @(negedge CLK);
    #1;
    Reset = 1'b0;
    mark();
  endtask
  initial begin
    do_reset();
    run(0, 50, 1'b0);
    expect_eq("uniform_valid_cnt", nvalid - s_valid, 24);
    expect_eq("uniform_zero_cnt", nz - s_z, 24);
    expect_eq("uniform_fdone_cnt", nfd - s_fd, 1);
    do_reset();
    run(1, 50, 1'b0);
    expect_eq("step_valid_cnt", nvalid - s_valid, 24);
    expect_eq("step_sat_cnt", nff - s_ff, 8);
    expect_eq("step_flat_cnt", nz - s_z, 16);
    do_reset();
    run(2, 50, 1'b0);
    expect_eq("ramp_80_cnt", n80 - s_80, 24);
    expect_eq("ramp_thr100_zero_cnt", t100z - s_t100z, 24);
    expect_eq("ramp_thr80_ff_cnt", t80ff - s_t80ff, 24);
    do_reset();
    run(2, 50, 1'b1);
    expect_eq("ramp_gated_valid_cnt", nvalid - s_valid, 24);
    expect_eq("ramp_gated_80_cnt", n80 - s_80, 24);
    expect_eq("ramp_gated_fdone_cnt", nfd - s_fd, 1);
    do_reset();
    run(3, 98, 1'b1);
    expect_eq("random_valid_cnt", nvalid - s_valid, 48);
    expect_eq("random_fdone_cnt", nfd - s_fd, 2);
    do_reset();
    mode = 3;
    for (int i = 0; i < 20; i++) cyc(1'b1);
    @(posedge CLK);
    #2;
    Reset = 1'b1;
    Enable = 1'b0;
    pos = 0;
    #1;
    expect_eq("async_rst_data", int'(d0), 0);
    expect_eq("async_rst_valid", int'(v0), 0);
    expect_eq("async_rst_fdone", int'(f0), 0);
    @(negedge CLK);
    #1;
    Reset = 1'b0;
    mark();
    run(2, 50, 1'b0);
    expect_eq("post_rst_valid_cnt", nvalid - s_valid, 24);
    expect_eq("post_rst_80_cnt", n80 - s_80, 24);
    expect_eq("post_rst_fdone_cnt", nfd - s_fd, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
